fetch_bus_arbiter: RTL and testbench

- Shares the single W_* memory bus between the four hardware threads' fetch/store requests.
- Sits between the per-thread FETCH request ports and the system bus.
- Round-robin arbitration, one outstanding bus transaction at a time.
- Registered strobe; single-cycle ack pulse back to the winning thread.

---
 rtl/fetch_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fetch_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bus_arbiter.sv
// rtl/fetch_bus_arbiter.sv - round-robin arbiter sharing one W_* bus between four thread fetch ports
// Optional bus-wait timeout is built when FETCH_ARB_TIMEOUT_EN is defined.
module fetch_bus_arbiter #(
    parameter int N_THREADS = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_THREADS-1:0]   req,
    input  logic [N_THREADS-1:0]   wr,
    input  logic [N_THREADS*AW-1:0] addr,
    input  logic [N_THREADS*DW-1:0] wdata,
    output logic [N_THREADS-1:0]   ack,
    output logic [DW-1:0]          rdata,
    output logic [N_THREADS-1:0]   grant,
    output logic                   err,
    output logic [AW-1:0]          W_ADDR,
    output logic [DW-1:0]          W_DATA_O,
    output logic                   W_WRITE,
    output logic                   W_STB,
    input  logic                   W_ACK,
    input  logic [DW-1:0]          W_DATA_I
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // The 2-bit thread id ties the arbiter to exactly four requesters.
    if (N_THREADS != 4 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fetch_bus_arbiter: N_THREADS must be 4 and TIMEOUT at least 1");
    end

    state_t                 state_q, state_d;
    logic [1:0]             last_q, last_d;
    logic [1:0]             owner_q, owner_d;
    logic [N_THREADS-1:0]   grant_q, grant_d;
    logic [N_THREADS-1:0]   ack_q, ack_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   stb_q, stb_d;
    logic                   write_q, write_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          data_q, data_d;

`ifdef FETCH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    logic                   win_valid;
    logic [1:0]             win_idx;

    // Search last+1, last+2, ... last+4 (mod 4); the first requester found wins.
    always_comb begin
        logic [1:0] idx;
        win_valid = 1'b0;
        win_idx   = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        stb_d   = stb_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef FETCH_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    addr_d           = addr[int'(win_idx)*AW +: AW];
                    data_d           = wdata[int'(win_idx)*DW +: DW];
                    write_d          = wr[win_idx];
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    stb_d            = 1'b1;
                    state_d          = BUS;
`ifdef FETCH_ARB_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end
            end
            BUS: begin
                if (W_ACK) begin
                    if (!write_q) begin
                        rdata_d = W_DATA_I;
                    end
                    stb_d   = 1'b0;
                    write_d = 1'b0;
                    ack_d   = grant_q;
                    last_d  = owner_q;
                    state_d = RESP;
                end
`ifdef FETCH_ARB_TIMEOUT_EN
                // Abandon a stalled bus: complete the thread with an error and a marker value.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = DW'(32'hDEAD_BEEF);
                    stb_d   = 1'b0;
                    write_d = 1'b0;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                ack_d   = '0;
                grant_d = '0;
`ifdef FETCH_ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            owner_q <= 2'd0;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            stb_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef FETCH_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            stb_q   <= stb_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef FETCH_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign grant    = grant_q;
    assign W_ADDR   = addr_q;
    assign W_DATA_O = data_q;
    assign W_WRITE  = write_q;
    assign W_STB    = stb_q;
`ifdef FETCH_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// tb/tb_fetch_bus_arbiter.sv - scoreboard bench for fetch_bus_arbiter with a modelled bus slave
module tb_fetch_bus_arbiter;

    localparam int TIMEOUT = 15;
    localparam logic [31:0] RD_XOR = 32'h5A5A_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, wr;
    logic [127:0] addr, wdata;
    logic [3:0]   ack, grant;
    logic [31:0]  rdata, W_ADDR, W_DATA_O, W_DATA_I;
    logic         err, W_WRITE, W_STB, W_ACK;

    fetch_bus_arbiter #(.N_THREADS(4), .AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .grant(grant), .err(err),
        .W_ADDR(W_ADDR), .W_DATA_O(W_DATA_O), .W_WRITE(W_WRITE), .W_STB(W_STB),
        .W_ACK(W_ACK), .W_DATA_I(W_DATA_I)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] ack; logic [31:0] rdata; logic err; } resp_t;
    typedef struct { logic [1:0] thr; logic [31:0] addr; logic [31:0] data; logic wr; } bus_t;

    resp_t       sb_resp[$];
    bus_t        sb_bus[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          bus_wait = 0;
    logic [31:0] exp_rdata = '0;

    int   stb_len = 0, last_stb_len = 0, rise_cyc = 0, ack_cyc = 0;
    logic stb_prev = 1'b0;
    bus_t cur_bus;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave: acks after bus_wait strobe cycles, read data derived from the address.
    initial begin
        int cnt = 0;
        W_ACK = 1'b0;
        W_DATA_I = '0;
        forever begin
            @(posedge clk);
            #1;
            if (W_STB) begin
                W_ACK    = (cnt == bus_wait);
                W_DATA_I = W_ADDR ^ RD_XOR;
                cnt++;
            end else begin
                W_ACK = 1'b0;
                cnt   = 0;
            end
        end
    end

    // Monitor: compares strobed bus phases and ack pulses against the scoreboard queues.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            check("grant_onehot", 64'($onehot0(grant)), 64'd1);
            check("ack_onehot", 64'($onehot0(ack)), 64'd1);
            if (W_STB) begin
                if (!stb_prev) begin
                    rise_cyc = cyc;
                    stb_len  = 0;
                    if (sb_bus.size() == 0) begin
                        check("bus_unexpected", 64'd1, 64'd0);
                        cur_bus = '{thr: 2'd0, addr: W_ADDR, data: W_DATA_O, wr: W_WRITE};
                    end else begin
                        cur_bus = sb_bus.pop_front();
                    end
                end
                stb_len++;
                check("bus_addr", 64'(W_ADDR), 64'(cur_bus.addr));
                check("bus_data_o", 64'(W_DATA_O), 64'(cur_bus.data));
                check("bus_write", 64'(W_WRITE), 64'(cur_bus.wr));
                check("bus_grant", 64'(grant), 64'(4'b0001 << cur_bus.thr));
            end else if (stb_prev) begin
                last_stb_len = stb_len;
            end
            stb_prev = W_STB;
            if (ack != 4'b0000) begin
                ack_cyc = cyc;
                if (sb_resp.size() == 0) begin
                    check("ack_unexpected", 64'(ack), 64'd0);
                end else begin
                    r = sb_resp.pop_front();
                    check("ack_vec", 64'(ack), 64'(r.ack));
                    check("ack_rdata", 64'(rdata), 64'(r.rdata));
                    check("ack_err", 64'(err), 64'(r.err));
                end
            end else begin
                check("err_idle", 64'(err), 64'd0);
            end
        end
    end

    task automatic issue(input int t, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[t]          = 1'b1;
        wr[t]           = w;
        addr[t*32 +: 32]  = a;
        wdata[t*32 +: 32] = d;
    endtask

    task automatic push_bus(input int t);
        bus_t b;
        b.thr  = 2'(t);
        b.addr = addr[t*32 +: 32];
        b.data = wdata[t*32 +: 32];
        b.wr   = wr[t];
        sb_bus.push_back(b);
    endtask

    task automatic expect_txn(input int t, input logic timed_out);
        resp_t r;
        push_bus(t);
        if (timed_out)
            exp_rdata = 32'hDEAD_BEEF;
        else if (!wr[t])
            exp_rdata = addr[t*32 +: 32] ^ RD_XOR;
        r.ack   = 4'b0001 << t;
        r.rdata = exp_rdata;
        r.err   = timed_out;
        sb_resp.push_back(r);
    endtask

    task automatic wait_ack(output logic [3:0] got);
        got = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                got = ack;
                break;
            end
        end
        if (got == 4'b0000) check("ack_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req = req & ~got;
    endtask

    initial begin
        logic [3:0] got;
        int prev;
        rst_n = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_stb", 64'(W_STB), 64'd0);
        check("rst_write", 64'(W_WRITE), 64'd0);
        check("rst_addr", 64'(W_ADDR), 64'd0);
        check("rst_data_o", 64'(W_DATA_O), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-wait read by thread 0.
        bus_wait = 0;
        issue(0, 1'b0, 32'h0000_0100, 32'h1111_0000);
        expect_txn(0, 1'b0);
        wait_ack(got);
        check("rd_ack", 64'(got), 64'b0001);
        check("rd_stb_len", 64'(last_stb_len), 64'd1);
        check("rd_ack_lat", 64'(ack_cyc - rise_cyc), 64'd1);

        // Write by thread 2 with three wait states.
        bus_wait = 3;
        issue(2, 1'b1, 32'h0000_0040, 32'hCAFE_0001);
        expect_txn(2, 1'b0);
        wait_ack(got);
        check("wr_ack", 64'(got), 64'b0100);
        check("wr_stb_len", 64'(last_stb_len), 64'd4);
        check("wr_rdata_kept", 64'(rdata), 64'(32'h5A5A_0100));

        // Rotation: after thread 2, search order is 3,0,1,2.
        bus_wait = 0;
        issue(0, 1'b0, 32'h0000_0200, 32'h0);
        issue(2, 1'b0, 32'h0000_0300, 32'h0);
        expect_txn(0, 1'b0);
        expect_txn(2, 1'b0);
        wait_ack(got);
        check("rot_first", 64'(got), 64'b0001);
        wait_ack(got);
        check("rot_second", 64'(got), 64'b0100);

        // Reset while the bus is stalled: no ack, outputs back to reset values.
        bus_wait = 1000;
        issue(1, 1'b1, 32'h0000_0500, 32'h5555_AAAA);
        push_bus(1);
        for (int i = 0; i < 20 && !W_STB; i++) @(negedge clk);
        check("mid_stb_seen", 64'(W_STB), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
        check("mid_rst_stb", 64'(W_STB), 64'd0);
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        check("mid_rst_addr", 64'(W_ADDR), 64'd0);
        repeat (4) @(negedge clk);
        bus_wait = 0;
        @(posedge clk);
        #1;
        issue(3, 1'b0, 32'h0000_0700, 32'h0);
        expect_txn(3, 1'b0);
        wait_ack(got);
        check("post_rst_ack", 64'(got), 64'b1000);

        // Fairness: all four request at once, one ack every 3 cycles in order 0..3.
        for (int t = 0; t < 4; t++)
            issue(t, (t % 2) == 1, 32'h0000_1000 + 32'(t) * 32'h10, 32'hF00D_0000 + 32'(t));
        for (int t = 0; t < 4; t++) expect_txn(t, 1'b0);
        prev = 0;
        for (int t = 0; t < 4; t++) begin
            wait_ack(got);
            check("fair_order", 64'(got), 64'(4'b0001 << t));
            if (t > 0) check("fair_spacing", 64'(ack_cyc - prev), 64'd3);
            prev = ack_cyc;
        end

`ifdef FETCH_ARB_TIMEOUT_EN
        // Stalled bus gives up after TIMEOUT strobe cycles.
        bus_wait = 1000;
        issue(0, 1'b0, 32'h0000_0900, 32'h0);
        expect_txn(0, 1'b1);
        wait_ack(got);
        check("to_ack", 64'(got), 64'b0001);
        check("to_stb_len", 64'(last_stb_len), 64'(TIMEOUT));
        bus_wait = 0;
`endif

        repeat (5) @(negedge clk);
        check("sb_resp_left", 64'(sb_resp.size()), 64'd0);
        check("sb_bus_left", 64'(sb_bus.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
